// File: rtl/ain_averager.sv
// ---------------------------------------------------------------------------
// ain_averager
//
// Per-channel block averager and limit monitor for the eight LTC2320 analog
// inputs, clocked in the 150 MHz domain directly behind the ADC interface.
//
// Each accepted frame is snapshotted, then walked through one channel per
// cycle by a time-multiplexed datapath. The datapath accumulates 2^AVG_LOG2
// frames per channel and publishes the eight truncated averages together
// with a one-cycle strobe. Every sample is also compared against a common
// threshold to set sticky per-channel fault flags. A frame that arrives
// while a previous one is still being processed is dropped and flagged as
// an overrun.
//
// Parameters
//   AVG_LOG2      log2 of frames per average (0..8)
//
// Ports
//   clk_150mhz    sole clock, rising edge
//   reset_150mhz  asynchronous active-high reset
//   ain_valid     one-cycle strobe; ain1..8_data stable while high
//   ain1..8_data  13-bit unsigned samples, channels 1..8
//   limit_value   13-bit unsigned over-limit threshold (strictly greater)
//   fault_clear   one-cycle pulse clearing fault_flags and overrun
//   avg_valid     one-cycle strobe marking a new set of averages
//   avg1..8_data  13-bit truncated averages, channels 1..8
//   fault_flags   sticky over-limit flags, bit k-1 = channel k
//   overrun       sticky; a frame arrived while busy and was dropped
//   busy          high while a frame is being processed
// ---------------------------------------------------------------------------
module ain_averager #(
   parameter int AVG_LOG2 = 4
) (
   input  logic        clk_150mhz,
   input  logic        reset_150mhz,
   input  logic        ain_valid,
   input  logic [12:0] ain1_data,
   input  logic [12:0] ain2_data,
   input  logic [12:0] ain3_data,
   input  logic [12:0] ain4_data,
   input  logic [12:0] ain5_data,
   input  logic [12:0] ain6_data,
   input  logic [12:0] ain7_data,
   input  logic [12:0] ain8_data,
   input  logic [12:0] limit_value,
   input  logic        fault_clear,
   output logic        avg_valid,
   output logic [12:0] avg1_data,
   output logic [12:0] avg2_data,
   output logic [12:0] avg3_data,
   output logic [12:0] avg4_data,
   output logic [12:0] avg5_data,
   output logic [12:0] avg6_data,
   output logic [12:0] avg7_data,
   output logic [12:0] avg8_data,
   output logic [7:0]  fault_flags,
   output logic        overrun,
   output logic        busy
);

   localparam int ACC_W  = 13 + AVG_LOG2;
   // A zero-width counter is not legal, so AVG_LOG2=0 keeps a 1-bit dummy
   // whose terminal value is 0: every frame is then the last frame.
   localparam int FCNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [2:0]        idx;
   logic [FCNT_W-1:0] fcnt;
   logic              last_frame;

   logic [12:0]       ain_data [8];
   logic [12:0]       snap     [8];
   logic [ACC_W-1:0]  acc      [8];
   logic [12:0]       res      [8];
   logic [12:0]       avg_q    [8];

   logic [12:0]       snap_cur;
   logic [ACC_W-1:0]  sum_cur;
   logic [7:0]        fault_set;
   logic              overrun_set;

   // Floor division by the frame count. The sum can never exceed
   // (2^13-1)*2^AVG_LOG2, so the shifted value always fits in 13 bits.
   function automatic logic [12:0] avg_trunc(input logic [ACC_W-1:0] sum);
      return 13'(sum >> AVG_LOG2);
   endfunction

   assign ain_data[0] = ain1_data;
   assign ain_data[1] = ain2_data;
   assign ain_data[2] = ain3_data;
   assign ain_data[3] = ain4_data;
   assign ain_data[4] = ain5_data;
   assign ain_data[5] = ain6_data;
   assign ain_data[6] = ain7_data;
   assign ain_data[7] = ain8_data;

   assign avg1_data = avg_q[0];
   assign avg2_data = avg_q[1];
   assign avg3_data = avg_q[2];
   assign avg4_data = avg_q[3];
   assign avg5_data = avg_q[4];
   assign avg6_data = avg_q[5];
   assign avg7_data = avg_q[6];
   assign avg8_data = avg_q[7];

   assign busy       = (state != IDLE);
   assign last_frame = (fcnt == FCNT_LAST);
   assign snap_cur   = snap[idx];
   assign sum_cur    = acc[idx] + ACC_W'(snap_cur);

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_150mhz or posedge reset_150mhz) begin
      if (reset_150mhz) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ain_valid) begin
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (idx == 3'd7) begin
               state_nxt = last_frame ? PUBLISH : IDLE;
            end
         end
         PUBLISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Snapshot, accumulate and publish datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk_150mhz or posedge reset_150mhz) begin
      if (reset_150mhz) begin
         idx       <= 3'd0;
         fcnt      <= '0;
         avg_valid <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            snap[k]  <= '0;
            acc[k]   <= '0;
            res[k]   <= '0;
            avg_q[k] <= '0;
         end
      end else begin
         avg_valid <= 1'b0;
         case (state)
            IDLE: begin
               // The snapshot decouples processing from the upstream data,
               // which is only guaranteed stable during the strobe cycle.
               if (ain_valid) begin
                  for (int k = 0; k < 8; k++) begin
                     snap[k] <= ain_data[k];
                  end
                  idx <= 3'd0;
               end
            end
            ACCUM: begin
               if (last_frame) begin
                  res[idx] <= avg_trunc(sum_cur);
                  acc[idx] <= '0;
               end else begin
                  acc[idx] <= sum_cur;
               end
               idx <= idx + 3'd1;
               if (idx == 3'd7) begin
                  fcnt <= last_frame ? '0 : fcnt + FCNT_W'(1);
               end
            end
            PUBLISH: begin
               // Staging through res keeps all eight outputs coherent: they
               // only ever change together with the avg_valid strobe.
               for (int k = 0; k < 8; k++) begin
                  avg_q[k] <= res[k];
               end
               avg_valid <= 1'b1;
            end
            default: begin
               idx <= 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky fault and overrun flags
   // ------------------------------------------------------------------
   always_comb begin
      fault_set = 8'd0;
      if ((state == ACCUM) && (snap_cur > limit_value)) begin
         fault_set[idx] = 1'b1;
      end
   end

   assign overrun_set = ain_valid && (state != IDLE);

   // A set condition on the same edge as fault_clear wins, so an event is
   // never lost to a host clear racing with it.
   always_ff @(posedge clk_150mhz or posedge reset_150mhz) begin
      if (reset_150mhz) begin
         fault_flags <= 8'd0;
         overrun     <= 1'b0;
      end else begin
         fault_flags <= (fault_clear ? 8'd0 : fault_flags) | fault_set;
         overrun     <= (fault_clear ? 1'b0 : overrun) | overrun_set;
      end
   end

endmodule

// File: tb/tb_ain_averager.sv
module tb_ain_averager;

   logic        clk_150mhz = 1'b0;
   logic        reset_150mhz;
   logic        ain_valid;
   logic [12:0] din [8];
   logic [12:0] limit_value;
   logic        fault_clear;

   logic        avg_valid2, overrun2, busy2;
   logic [12:0] avg2 [8];
   logic [7:0]  fault2;

   logic        avg_valid0, overrun0, busy0;
   logic [12:0] avg0 [8];
   logic [7:0]  fault0;

   int chk_cnt = 0;
   int err_cnt = 0;
   int vld2_cnt = 0;
   int base;

   always #5 clk_150mhz = ~clk_150mhz;

   ain_averager #(.AVG_LOG2(2)) u_avg2 (
      .clk_150mhz  (clk_150mhz),
      .reset_150mhz(reset_150mhz),
      .ain_valid   (ain_valid),
      .ain1_data   (din[0]),
      .ain2_data   (din[1]),
      .ain3_data   (din[2]),
      .ain4_data   (din[3]),
      .ain5_data   (din[4]),
      .ain6_data   (din[5]),
      .ain7_data   (din[6]),
      .ain8_data   (din[7]),
      .limit_value (limit_value),
      .fault_clear (fault_clear),
      .avg_valid   (avg_valid2),
      .avg1_data   (avg2[0]),
      .avg2_data   (avg2[1]),
      .avg3_data   (avg2[2]),
      .avg4_data   (avg2[3]),
      .avg5_data   (avg2[4]),
      .avg6_data   (avg2[5]),
      .avg7_data   (avg2[6]),
      .avg8_data   (avg2[7]),
      .fault_flags (fault2),
      .overrun     (overrun2),
      .busy        (busy2)
   );

   ain_averager #(.AVG_LOG2(0)) u_avg0 (
      .clk_150mhz  (clk_150mhz),
      .reset_150mhz(reset_150mhz),
      .ain_valid   (ain_valid),
      .ain1_data   (din[0]),
      .ain2_data   (din[1]),
      .ain3_data   (din[2]),
      .ain4_data   (din[3]),
      .ain5_data   (din[4]),
      .ain6_data   (din[5]),
      .ain7_data   (din[6]),
      .ain8_data   (din[7]),
      .limit_value (limit_value),
      .fault_clear (fault_clear),
      .avg_valid   (avg_valid0),
      .avg1_data   (avg0[0]),
      .avg2_data   (avg0[1]),
      .avg3_data   (avg0[2]),
      .avg4_data   (avg0[3]),
      .avg5_data   (avg0[4]),
      .avg6_data   (avg0[5]),
      .avg7_data   (avg0[6]),
      .avg8_data   (avg0[7]),
      .fault_flags (fault0),
      .overrun     (overrun0),
      .busy        (busy0)
   );

   always @(negedge clk_150mhz) begin
      if (avg_valid2) vld2_cnt <= vld2_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_150mhz);
   endtask

   // Pulses ain_valid for one edge (T); returns half a cycle after T.
   task automatic frame();
      @(negedge clk_150mhz);
      ain_valid = 1'b1;
      @(negedge clk_150mhz);
      ain_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_150mhz);
      reset_150mhz = 1'b1;
      cyc(2);
      reset_150mhz = 1'b0;
   endtask

   task automatic set_all(input logic [12:0] v);
      for (int k = 0; k < 8; k++) din[k] = v;
   endtask

   initial begin
      reset_150mhz = 1'b1;
      ain_valid    = 1'b0;
      fault_clear  = 1'b0;
      limit_value  = 13'd8191;
      set_all(13'd0);
      cyc(3);
      chk("rst_avg_valid", avg_valid2, 0);
      chk("rst_avg1", avg2[0], 0);
      chk("rst_avg8", avg2[7], 0);
      chk("rst_fault", fault2, 0);
      chk("rst_overrun", overrun2, 0);
      chk("rst_busy", busy2, 0);
      reset_150mhz = 1'b0;
      cyc(2);

      // Constant inputs 100*N, four frames 100 cycles apart
      for (int k = 0; k < 8; k++) din[k] = 13'((k + 1) * 100);
      base = vld2_cnt;
      for (int f = 0; f < 3; f++) begin
         frame();
         cyc(99);
      end
      chk("const_no_early_pulse", vld2_cnt - base, 0);
      frame();
      chk("const_busy_after_T", busy2, 1);
      cyc(8);
      chk("const_vld_T8", avg_valid2, 0);
      cyc(1);
      chk("const_vld_T9", avg_valid2, 1);
      for (int k = 0; k < 8; k++) chk($sformatf("const_avg%0d", k + 1), avg2[k], (k + 1) * 100);
      cyc(1);
      chk("const_vld_T10", avg_valid2, 0);
      chk("const_busy_T10", busy2, 0);
      cyc(5);
      chk("const_one_pulse", vld2_cnt - base, 1);
      chk("const_fault", fault2, 0);

      // Full-scale accumulation: 8191,8191,8191,8190 -> 8190
      do_reset();
      for (int f = 0; f < 4; f++) begin
         din[0] = (f == 3) ? 13'd8190 : 13'd8191;
         frame();
         if (f < 3) cyc(20);
      end
      cyc(9);
      chk("fs_vld", avg_valid2, 1);
      chk("fs_avg1", avg2[0], 8190);
      chk("fs_avg2", avg2[1], 200);
      cyc(10);

      // Limit monitor
      limit_value = 13'd1000;
      set_all(13'd1000);
      din[2] = 13'd1001;
      frame();
      cyc(2);
      chk("lim_before_T3", fault2, 0);
      cyc(1);
      chk("lim_after_T3", fault2, 8'h04);
      cyc(20);
      din[2] = 13'd1000;
      frame();
      cyc(20);
      chk("lim_sticky", fault2, 8'h04);
      @(negedge clk_150mhz);
      fault_clear = 1'b1;
      @(negedge clk_150mhz);
      fault_clear = 1'b0;
      chk("lim_cleared", fault2, 0);
      cyc(5);
      din[2] = 13'd1001;
      frame();
      cyc(2);
      chk("lim_pre_clash", fault2, 0);
      fault_clear = 1'b1;
      @(negedge clk_150mhz);
      fault_clear = 1'b0;
      chk("lim_set_wins", fault2, 8'h04);
      cyc(20);

      // Overrun: pulse at T and T+5 dropped, T+10 accepted
      do_reset();
      limit_value = 13'd8191;
      for (int k = 0; k < 8; k++) din[k] = 13'(1001 + k);
      frame();
      cyc(4);
      set_all(13'd5000);
      ain_valid = 1'b1;
      @(negedge clk_150mhz);
      ain_valid = 1'b0;
      chk("ovr_set", overrun2, 1);
      for (int k = 0; k < 8; k++) din[k] = 13'(1001 + k);
      cyc(4);
      ain_valid = 1'b1;
      @(negedge clk_150mhz);
      ain_valid = 1'b0;
      chk("ovr_T10_accepted", busy2, 1);
      cyc(20);
      frame();
      cyc(20);
      frame();
      cyc(9);
      chk("ovr_vld", avg_valid2, 1);
      for (int k = 0; k < 8; k++) chk($sformatf("ovr_avg%0d", k + 1), avg2[k], 1001 + k);
      chk("ovr_sticky", overrun2, 1);
      cyc(10);

      // Reset in the middle of the 2nd frame, then four clean frames
      set_all(13'd300);
      frame();
      cyc(20);
      frame();
      cyc(3);
      reset_150mhz = 1'b1;
      @(negedge clk_150mhz);
      chk("mid_rst_vld", avg_valid2, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("mid_rst_avg%0d", k + 1), avg2[k], 0);
      chk("mid_rst_fault", fault2, 0);
      chk("mid_rst_overrun", overrun2, 0);
      chk("mid_rst_busy", busy2, 0);
      reset_150mhz = 1'b0;
      set_all(13'd500);
      cyc(5);
      base = vld2_cnt;
      for (int f = 0; f < 3; f++) begin
         frame();
         cyc(20);
      end
      chk("post_rst_no_early", vld2_cnt - base, 0);
      frame();
      cyc(9);
      chk("post_rst_vld", avg_valid2, 1);
      for (int k = 0; k < 8; k++) chk($sformatf("post_rst_avg%0d", k + 1), avg2[k], 500);
      cyc(10);

      // AVG_LOG2=0: each frame published as-is
      for (int f = 0; f < 4; f++) begin
         set_all((f % 2 == 1) ? 13'd8191 : 13'd0);
         din[4] = (f % 2 == 1) ? 13'd0 : 13'd8191;
         frame();
         cyc(8);
         chk($sformatf("a0_vld_T8_f%0d", f), avg_valid0, 0);
         cyc(1);
         chk($sformatf("a0_vld_f%0d", f), avg_valid0, 1);
         chk($sformatf("a0_avg1_f%0d", f), avg0[0], (f % 2 == 1) ? 8191 : 0);
         chk($sformatf("a0_avg5_f%0d", f), avg0[4], (f % 2 == 1) ? 0 : 8191);
         chk($sformatf("a0_avg8_f%0d", f), avg0[7], (f % 2 == 1) ? 8191 : 0);
         cyc(10);
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
